dm: RTL and testbench

DM -- requirements
Module: dm

---
 rtl/dm.sv | 105 ++++++++++
 tb/tb_dm.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dm.sv
// Data memory: 4096 x 32-bit little-endian storage with word/halfword/byte
// stores at the rising clock edge and combinational sign/zero-extending loads.
module dm (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  StoreType,
  input  logic [1:0]  LoadType,
  input  logic        SignRead,
  input  logic [31:0] WPC,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic [31:0] RD
);

  localparam int unsigned DEPTH = 4096;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2,
    SZ_NONE = 2'd3
  } size_e;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d;
  logic [11:0] idx;
  logic [31:0] word;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        we;

  // WPC and the upper address bits only matter for tracing and aliasing.
  logic unused_bits;
  assign unused_bits = ^{WPC, Addr[31:14]};

  assign idx  = Addr[13:2];
  assign word = mem_q[idx];
  assign we   = MemWrite && (StoreType != SZ_NONE);

  // Replicate the right-aligned store data across all lanes; byte enables pick.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    be    = 4'b0000;
    wdata = '0;
    case (StoreType)
      SZ_WORD: begin
        be    = 4'b1111;
        wdata = WD;
      end
      SZ_HALF: begin
        be    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WD[15:0]}};
      end
      SZ_BYTE: begin
        be    = 4'b0001 << Addr[1:0];
        wdata = {4{WD[7:0]}};
      end
      default: begin
        be    = 4'b0000;
        wdata = '0;
      end
    endcase
  end

  always_comb begin
    mem_d = word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) mem_d[8*k +: 8] = wdata[8*k +: 8];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: the whole array must clear in one edge, so it is built from
      // flops rather than a RAM macro; reset also suppresses any store.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      // NOTE: non-blocking so a same-edge load still sees the old word.
      mem_q[idx] <= mem_d;
    end
  end

  logic [15:0] half_v;
  logic [31:0] shifted;
  logic [7:0]  byte_v;

  assign half_v  = Addr[1] ? word[31:16] : word[15:0];
  assign shifted = word >> {Addr[1:0], 3'b000};
  assign byte_v  = shifted[7:0];

  always_comb begin
    RD = '0;
    if (MemRead) begin
      case (LoadType)
        SZ_WORD: RD = word;
        SZ_HALF: RD = {{16{SignRead & half_v[15]}}, half_v};
        SZ_BYTE: RD = {{24{SignRead & byte_v[7]}}, byte_v};
        default: RD = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dm.sv
// Scoreboard bench for dm: stimulus pushes hand-computed load results,
// a negedge monitor pops and compares them against RD.
module tb_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [1:0]  store_type = 2'd3;
  logic [1:0]  load_type = 2'd3;
  logic        sign_read = 1'b0;
  logic [31:0] wpc = '0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  logic chk_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dm dut (
    .Clock    (clk),
    .Reset    (rst),
    .MemWrite (mem_write),
    .MemRead  (mem_read),
    .StoreType(store_type),
    .LoadType (load_type),
    .SignRead (sign_read),
    .WPC      (wpc),
    .Addr     (addr),
    .WD       (wd),
    .RD       (rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: output strobe with empty scoreboard");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, rd, e.exp);
      end
    end
  end

  // One clock cycle of stimulus; when chk is set the expected RD is queued.
  task automatic cyc(input logic r, input logic we, input logic [1:0] st,
                     input logic re, input logic [1:0] lt, input logic sg,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp, input string name);
    exp_t e;
    rst = r; mem_write = we; store_type = st; mem_read = re;
    load_type = lt; sign_read = sg; addr = a; wd = d; wpc = wpc + 32'd4;
    if (chk) begin
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
    end
    chk_valid = chk;
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic store(input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, st, 1'b0, 2'd3, 1'b0, a, d, 1'b0, '0, "");
  endtask

  task automatic load(input logic [1:0] lt, input logic sg, input logic [31:0] a,
                      input logic [31:0] exp, input string name);
    cyc(1'b0, 1'b0, 2'd3, 1'b1, lt, sg, a, '0, 1'b1, exp, name);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0, '0, '0, 1'b0, '0, "");
    load(2'd0, 1'b0, 32'h0, 32'h0, "reset_lw0");
    load(2'd0, 1'b0, 32'h3FFC, 32'h0, "reset_lw_top");

    // Store sequence building 0xEEBB56DD at word 0.
    store(2'd0, 32'h0, 32'h12345678);
    load(2'd0, 1'b0, 32'h0, 32'h12345678, "sw0");
    store(2'd1, 32'h2, 32'h0000AABB);
    load(2'd0, 1'b0, 32'h0, 32'hAABB5678, "sh_hi");
    store(2'd2, 32'h0, 32'hAABBCCDD);
    load(2'd0, 1'b0, 32'h0, 32'hAABB56DD, "sb0");
    store(2'd2, 32'h3, 32'hAABBCCEE);
    load(2'd0, 1'b0, 32'h3, 32'hEEBB56DD, "sb3");

    // Low halfword store (Addr[0] ignored) and a middle byte.
    store(2'd0, 32'h10, 32'hCAFEF00D);
    store(2'd1, 32'h11, 32'h99991234);
    load(2'd0, 1'b0, 32'h10, 32'hCAFE1234, "sh_lo");
    store(2'd2, 32'h11, 32'h00000077);
    load(2'd0, 1'b0, 32'h10, 32'hCAFE7734, "sb1");

    // Byte and halfword loads.
    load(2'd2, 1'b1, 32'h0, 32'hFFFFFFDD, "lb0");
    load(2'd2, 1'b0, 32'h0, 32'h000000DD, "lbu0");
    load(2'd2, 1'b1, 32'h3, 32'hFFFFFFEE, "lb3");
    load(2'd2, 1'b0, 32'h2, 32'h000000BB, "lbu2");
    load(2'd2, 1'b1, 32'h1, 32'h00000056, "lb1");
    load(2'd1, 1'b1, 32'h0, 32'h000056DD, "lh0");
    load(2'd1, 1'b0, 32'h0, 32'h000056DD, "lhu0");
    load(2'd1, 1'b1, 32'h2, 32'hFFFFEEBB, "lh2");
    load(2'd1, 1'b0, 32'h2, 32'h0000EEBB, "lhu2");
    load(2'd0, 1'b0, 32'h0, 32'hEEBB56DD, "lw0");

    // RD gating, suppressed stores, aliasing.
    cyc(1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 32'h0, '0, 1'b1, 32'h0, "noread_w");
    cyc(1'b0, 1'b0, 2'd3, 1'b0, 2'd1, 1'b1, 32'h2, '0, 1'b1, 32'h0, "noread_h");
    cyc(1'b0, 1'b0, 2'd3, 1'b0, 2'd2, 1'b1, 32'h3, '0, 1'b1, 32'h0, "noread_b");
    load(2'd3, 1'b1, 32'h0, 32'h0, "lt3");
    store(2'd3, 32'h0, 32'hFFFFFFFF);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, '0, "");
    load(2'd0, 1'b0, 32'h0, 32'hEEBB56DD, "nostore");
    load(2'd0, 1'b0, 32'h4000, 32'hEEBB56DD, "alias_rd");
    store(2'd0, 32'h4004, 32'h11112222);
    load(2'd0, 1'b0, 32'h4, 32'h11112222, "alias_wr");

    // Simultaneous write and read: old value before the edge, new one after.
    cyc(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h12345678, 1'b1, 32'hEEBB56DD, "rw_before");
    cyc(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h12345678, 1'b1, 32'h12345678, "rw_after");

    // Reset wins over a same-edge store and clears every word.
    store(2'd0, 32'h20, 32'h5555AAAA);
    load(2'd0, 1'b0, 32'h20, 32'h5555AAAA, "pre_reset");
    cyc(1'b1, 1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, '0, "");
    load(2'd0, 1'b0, 32'h0, 32'h0, "rst_wins");
    load(2'd0, 1'b0, 32'h20, 32'h0, "rst_clr20");
    load(2'd0, 1'b0, 32'h4, 32'h0, "rst_clr4");

    repeat (2) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected responses never observed", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
